// File: rtl/tile_pad_sequencer_pkg.sv
// Shared constants and beat bundle for the multi-channel tile padder.
// Sizes here are fixed for every channel of the sequencer.
package tile_pad_sequencer_pkg;

  localparam int LANES           = 16;
  localparam int LANE_W          = 8;
  localparam int SZI             = 16;
  localparam int MIN_TILE_SIZE_N = 16;
  localparam int MAX_TILE_SIZE_M = 512;

  localparam int BEAT_W = LANES * LANE_W;
  localparam int TSZ_W  = $clog2(MAX_TILE_SIZE_M + 1);
  localparam int RD_W   = $clog2(MAX_TILE_SIZE_M);
  localparam int WIN_W  = $clog2(SZI);

  typedef struct packed {
    logic [BEAT_W-1:0] value;
    logic              valid;
    logic              new_tile;
  } beat_t;

  // Last read-count index: clamp(m, MIN, MAX) - 1 (zero maps to MIN).
  function automatic logic [RD_W-1:0] pad_last(
    input logic [TSZ_W-1:0] m
  );
    logic [TSZ_W-1:0] p;
    if (m > TSZ_W'(MAX_TILE_SIZE_M))
      p = TSZ_W'(MAX_TILE_SIZE_M);
    else if (m < TSZ_W'(MIN_TILE_SIZE_N))
      p = TSZ_W'(MIN_TILE_SIZE_N);
    else
      p = m;
    return RD_W'(p - TSZ_W'(1));
  endfunction

endpackage

// File: rtl/tile_pad_channel.sv
// One channel: valid-window gate with pad/hold, plus tile-read counter.
// All outputs are registered one cycle after the staged beat.
module tile_pad_channel
  import tile_pad_sequencer_pkg::*;
#(
  parameter int EARLY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  beat_t            s,
  input  logic             start_rd,
  input  logic [TSZ_W-1:0] tile_size_m,
  input  logic             pad_mode,
  output beat_t            q,
  output logic             done,
  output logic             done_early,
  output logic             overrun
);

  typedef enum logic { W_IDLE, W_ACTIVE } win_st_t;
  typedef enum logic { R_IDLE, R_COUNT } rd_st_t;

  win_st_t           win_st;
  logic [WIN_W-1:0]  win_cnt;
  logic [BEAT_W-1:0] hold;
  logic              in_win;
  logic [WIN_W-1:0]  cur_cnt;

  rd_st_t            rd_st, rd_st_n;
  logic [RD_W-1:0]   rd_cnt, rd_cnt_n;
  logic [RD_W-1:0]   lim, lim_n;
  logic              ovr_set;

  // cur_cnt is the window index of the beat being presented now.
  always_comb begin
    in_win  = s.new_tile || (win_st == W_ACTIVE);
    cur_cnt = s.new_tile ? '0 : win_cnt;
  end

  always_comb begin
    rd_st_n  = rd_st;
    rd_cnt_n = rd_cnt;
    lim_n    = lim;
    ovr_set  = 1'b0;
    unique case (rd_st)
      R_IDLE: begin
        if (start_rd) begin
          rd_st_n  = R_COUNT;
          rd_cnt_n = '0;
          lim_n    = pad_last(tile_size_m);
        end
      end
      R_COUNT: begin
        if (rd_cnt == lim) begin
          if (start_rd) begin
            rd_cnt_n = '0;
            lim_n    = pad_last(tile_size_m);
          end else begin
            rd_st_n = R_IDLE;
          end
        end else begin
          rd_cnt_n = rd_cnt + RD_W'(1);
          ovr_set  = start_rd;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_st     <= W_IDLE;
      win_cnt    <= '0;
      hold       <= '0;
      q          <= '0;
      rd_st      <= R_IDLE;
      rd_cnt     <= '0;
      lim        <= '0;
      done       <= 1'b0;
      done_early <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (in_win) begin
        win_st  <= (cur_cnt == WIN_W'(SZI - 1)) ? W_IDLE : W_ACTIVE;
        win_cnt <= cur_cnt + WIN_W'(1);
        hold    <= s.value;
      end
      q.value    <= in_win ? s.value : (pad_mode ? hold : '0);
      q.valid    <= in_win & s.valid;
      q.new_tile <= s.new_tile;

      rd_st      <= rd_st_n;
      rd_cnt     <= rd_cnt_n;
      lim        <= lim_n;
      done       <= (rd_st_n == R_COUNT) && (rd_cnt_n == lim_n);
      done_early <= (rd_st_n == R_COUNT) &&
                    (rd_cnt_n == lim_n - RD_W'(EARLY));
      overrun    <= overrun | ovr_set;
    end
  end

endmodule

// File: rtl/tile_pad_sequencer.sv
// Multi-channel tile padder: input staging and per-channel bus slicing.
// Each channel runs an independent tile_pad_channel.
module tile_pad_sequencer
  import tile_pad_sequencer_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int EARLY  = 3,
  parameter int IN_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH*BEAT_W-1:0] d_value,
  input  logic [NCH-1:0]        d_valid,
  input  logic [NCH-1:0]        d_new_tile,
  input  logic [NCH-1:0]        start_rd,
  input  logic [TSZ_W-1:0]      tile_size_m,
  input  logic                  pad_mode,
  output logic [NCH*BEAT_W-1:0] q_value,
  output logic [NCH-1:0]        q_valid,
  output logic [NCH-1:0]        q_new_tile,
  output logic [NCH-1:0]        done,
  output logic [NCH-1:0]        done_early,
  output logic [NCH-1:0]        overrun
);

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    beat_t d_beat;
    beat_t q_beat;
    beat_t stg [IN_LAT];

    assign d_beat.value    = d_value[ch*BEAT_W +: BEAT_W];
    assign d_beat.valid    = d_valid[ch];
    assign d_beat.new_tile = d_new_tile[ch];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < IN_LAT; i++) stg[i] <= '0;
      end else begin
        stg[0] <= d_beat;
        for (int i = 1; i < IN_LAT; i++) stg[i] <= stg[i-1];
      end
    end

    tile_pad_channel #(
      .EARLY(EARLY)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .s          (stg[IN_LAT-1]),
      .start_rd   (start_rd[ch]),
      .tile_size_m(tile_size_m),
      .pad_mode   (pad_mode),
      .q          (q_beat),
      .done       (done[ch]),
      .done_early (done_early[ch]),
      .overrun    (overrun[ch])
    );

    assign q_value[ch*BEAT_W +: BEAT_W] = q_beat.value;
    assign q_valid[ch]    = q_beat.valid;
    assign q_new_tile[ch] = q_beat.new_tile;
  end

endmodule
